pif_rom_reader: RTL and testbench

PIF_ROM_READER -- requirements
Module: pif_rom_reader

---
 rtl/pif_pkg.sv | 24 ++
 rtl/pif_word_fifo.sv | 56 +++++
 rtl/pif_rom_reader.sv | 135 +++++++++++++
 tb/tb_pif_rom_reader.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pif_pkg.sv
// Shared types and constants for the PIF boot-ROM burst reader.
package pif_pkg;

    localparam int ROM_ADDR_W     = 11;
    localparam int WORD_ADDR_W    = 9;
    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_W         = 8 * BYTES_PER_WORD;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } pif_state_e;

    typedef struct packed {
        logic              last;
        logic [WORD_W-1:0] data;
    } pif_word_t;

    function automatic logic [ROM_ADDR_W-1:0] word_to_byte_addr(input logic [WORD_ADDR_W-1:0] wa);
        return {wa, 2'b00};
    endfunction

endpackage

// File: rtl/pif_word_fifo.sv
// Small FIFO of assembled words (data + last); simultaneous push and pop both take effect.
module pif_word_fifo
    import pif_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  pif_word_t                  push_word,
    input  logic                       pop,
    output pif_word_t                  pop_word,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    pif_word_t       mem [DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic            do_push, do_pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    // A pop frees the slot a same-cycle push needs when full.
    assign do_push  = push && (!full || do_pop);
    assign pop_word = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_word;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_next(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pif_rom_reader.sv
// Reads word bursts from the byte-wide PIF boot ROM, assembling little-endian 32-bit words into a FIFO.
module pif_rom_reader
    import pif_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [WORD_ADDR_W-1:0] req_addr,
    input  logic [3:0]             req_len,
    output logic [ROM_ADDR_W-1:0]  rom_address,
    output logic                   rom_oe,
    input  logic                   rom_valid,
    input  logic [7:0]             rom_q,
    output logic                   word_valid,
    input  logic                   word_ready,
    output logic [WORD_W-1:0]      word_data,
    output logic                   word_last,
    output logic                   busy
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    pif_state_e            state;
    logic [ROM_ADDR_W-1:0] rd_addr;
    logic [4:0]            words_left;
    logic [1:0]            tx_idx, rx_idx;
    logic [3:0]            len_q, rx_word;
    logic [2:0]            inflight;
    logic [23:0]           asm_q;
    logic                  rd_pend;

    logic [CW-1:0]         fifo_count;
    logic                  fifo_full, fifo_empty;
    logic [3:0]            occ;
    logic                  start_ok, issue, last_issue, word_start;
    logic                  rx_fire, push, pop, last_xfer;
    pif_word_t             push_word, pop_word;

    // A new word is only started when a FIFO slot is guaranteed for it.
    assign occ        = 4'(fifo_count) + 4'(inflight);
    assign start_ok   = !fifo_full && (occ < 4'(FIFO_DEPTH));
    assign issue      = (state == ST_FETCH) && ((tx_idx != 2'd0) || start_ok);
    assign word_start = issue && (tx_idx == 2'd0);
    assign last_issue = issue && (tx_idx == LAST_BYTE) && (words_left == 5'd1);

    // Bytes are only accepted when a read was issued the cycle before.
    assign rx_fire    = rom_valid && rd_pend;
    assign push       = rx_fire && (rx_idx == LAST_BYTE);
    assign push_word  = '{last: (rx_word == len_q), data: {rom_q, asm_q}};
    assign pop        = word_valid && word_ready;
    assign last_xfer  = pop && word_last;

    assign req_ready  = (state == ST_IDLE);
    assign busy       = (state != ST_IDLE);
    assign word_valid = !fifo_empty;
    assign word_data  = pop_word.data;
    assign word_last  = pop_word.last;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            rom_oe      <= 1'b0;
            rom_address <= '0;
            rd_addr     <= '0;
            words_left  <= '0;
            tx_idx      <= '0;
            rx_idx      <= '0;
            len_q       <= '0;
            rx_word     <= '0;
            inflight    <= '0;
            asm_q       <= '0;
            rd_pend     <= 1'b0;
        end else begin
            rom_oe  <= issue;
            rd_pend <= rom_oe;

            if (issue) begin
                rom_address <= rd_addr;
                rd_addr     <= rd_addr + 1'b1;
                tx_idx      <= tx_idx + 1'b1;
                if (tx_idx == LAST_BYTE) words_left <= words_left - 1'b1;
            end

            case ({word_start, push})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase

            if (rx_fire) begin
                rx_idx <= rx_idx + 1'b1;
                case (rx_idx)
                    2'd0:    asm_q[7:0]   <= rom_q;
                    2'd1:    asm_q[15:8]  <= rom_q;
                    2'd2:    asm_q[23:16] <= rom_q;
                    default: rx_word      <= rx_word + 1'b1;
                endcase
            end

            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        state      <= ST_FETCH;
                        rd_addr    <= word_to_byte_addr(req_addr);
                        words_left <= 5'(req_len) + 5'd1;
                        len_q      <= req_len;
                        tx_idx     <= '0;
                        rx_idx     <= '0;
                        rx_word    <= '0;
                    end
                end
                ST_FETCH: if (last_issue) state <= ST_DRAIN;
                ST_DRAIN: if (last_xfer)  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    pif_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_word (push_word),
        .pop       (pop),
        .pop_word  (pop_word),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_pif_rom_reader.sv
// Scoreboard bench for pif_rom_reader with a one-cycle-latency byte ROM model.
module tb_pif_rom_reader;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [8:0]  req_addr = '0;
    logic [3:0]  req_len = '0;
    logic [10:0] rom_address;
    logic        rom_oe;
    logic        rom_valid;
    logic        rom_valid_m = 1'b0;
    logic        stray = 1'b0;
    logic [7:0]  rom_q = '0;
    logic        word_valid;
    logic        word_ready = 1'b1;
    logic [31:0] word_data;
    logic        word_last;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int n_rx     = 0;
    logic [32:0] exp_q[$];
    logic [32:0] mon_exp;

    always #5 clk = ~clk;

    pif_rom_reader #(.FIFO_DEPTH(2)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_len     (req_len),
        .rom_address (rom_address),
        .rom_oe      (rom_oe),
        .rom_valid   (rom_valid),
        .rom_q       (rom_q),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .word_data   (word_data),
        .word_last   (word_last),
        .busy        (busy)
    );

    function automatic logic [31:0] rom_word(input logic [8:0] n);
        case (n)
            9'd0:    return 32'h3C09_3400;
            9'd1:    return 32'h4089_6000;
            9'd511:  return 32'hFFFF_FFFF;
            default: return {7'h55, n, 16'h0000} ^ (32'(n) * 32'h0001_0203);
        endcase
    endfunction

    function automatic logic [7:0] rom_byte(input logic [10:0] a);
        logic [31:0] w;
        w = rom_word(a[10:2]);
        return w[{a[1:0], 3'b000} +: 8];
    endfunction

    // ROM: data and valid one cycle after the strobe.
    assign rom_valid = rom_valid_m | stray;
    always @(posedge clk) begin
        rom_valid_m <= rom_oe;
        rom_q       <= rom_byte(rom_address);
    end

    always @(negedge clk) begin
        if (reset_n && word_valid && word_ready) begin
            n_checks++;
            n_rx++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_underflow: got last=%0b data=%h, expected no word", word_last, word_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({word_last, word_data} !== mon_exp) begin
                    n_fail++;
                    $display("FAIL sb_word: got last=%0b data=%h, expected last=%0b data=%h",
                             word_last, word_data, mon_exp[32], mon_exp[31:0]);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called at posedge+#1 with the reader idle; returns at #1 after the accepting edge.
    task automatic send_req(input logic [8:0] addr, input logic [3:0] len);
        logic [8:0] a;
        for (int w = 0; w <= int'(len); w++) begin
            a = addr + 9'(w);
            exp_q.push_back({(w == int'(len)), rom_word(a)});
        end
        req_valid = 1'b1;
        req_addr  = addr;
        req_len   = len;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input int limit, output bit to);
        to = 1'b1;
        for (int i = 0; i < limit; i++) begin
            if (req_ready && exp_q.size() == 0) begin
                to = 1'b0;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        #12;
        n_checks++; if (req_ready !== 1'b1)      begin n_fail++; $display("FAIL rst_req_ready: got %b, expected 1", req_ready); end
        n_checks++; if (rom_oe !== 1'b0)         begin n_fail++; $display("FAIL rst_rom_oe: got %b, expected 0", rom_oe); end
        n_checks++; if (rom_address !== 11'h0)   begin n_fail++; $display("FAIL rst_rom_address: got %h, expected 000", rom_address); end
        n_checks++; if (word_valid !== 1'b0)     begin n_fail++; $display("FAIL rst_word_valid: got %b, expected 0", word_valid); end
        n_checks++; if (word_data !== 32'h0)     begin n_fail++; $display("FAIL rst_word_data: got %h, expected 0", word_data); end
        n_checks++; if (word_last !== 1'b0)      begin n_fail++; $display("FAIL rst_word_last: got %b, expected 0", word_last); end
        n_checks++; if (busy !== 1'b0)           begin n_fail++; $display("FAIL rst_busy: got %b, expected 0", busy); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single;
        logic [15:0] oe_bits = '0;
        int first_wv = -1;
        bit to;
        word_ready = 1'b1;
        send_req(9'd0, 4'd0);
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (rom_oe) oe_bits[c] = 1'b1;
            if (word_valid && first_wv < 0) begin
                first_wv = c;
                n_checks++;
                if ({word_last, word_data} !== {1'b1, 32'h3C09_3400}) begin
                    n_fail++; $display("FAIL single_word: got last=%0b data=%h, expected last=1 data=3c093400", word_last, word_data);
                end
            end
        end
        n_checks++; if (oe_bits !== 16'h001E) begin n_fail++; $display("FAIL single_oe_cycles: got %h, expected 001e", oe_bits); end
        n_checks++; if (first_wv != 6) begin n_fail++; $display("FAIL single_latency: got cycle %0d, expected 6", first_wv); end
        wait_idle(30, to);
        n_checks++; if (to || busy !== 1'b0) begin n_fail++; $display("FAIL single_idle: timeout=%0b busy=%b, expected idle", to, busy); end
    endtask

    task automatic test_two;
        int oe_n = 0, run = 0, max_run = 0;
        bit to;
        send_req(9'd0, 4'd1);
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk); #1;
            if (rom_oe) begin oe_n++; run++; if (run > max_run) max_run = run; end
            else run = 0;
        end
        n_checks++; if (oe_n != 8 || max_run != 8) begin n_fail++; $display("FAIL two_oe: got %0d reads run %0d, expected 8 run 8", oe_n, max_run); end
        wait_idle(30, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL two_idle: timeout, expected idle"); end
    endtask

    task automatic test_wrap;
        logic [10:0] addrs[$];
        logic [10:0] ea;
        bit to;
        send_req(9'd511, 4'd1);
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk); #1;
            if (rom_oe) addrs.push_back(rom_address);
        end
        n_checks++; if (addrs.size() != 8) begin n_fail++; $display("FAIL wrap_count: got %0d, expected 8", addrs.size()); end
        for (int i = 0; i < addrs.size() && i < 8; i++) begin
            ea = 11'h7FC + 11'(i);
            n_checks++;
            if (addrs[i] !== ea) begin n_fail++; $display("FAIL wrap_addr[%0d]: got %h, expected %h", i, addrs[i], ea); end
        end
        wait_idle(30, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL wrap_idle: timeout, expected idle"); end
    endtask

    task automatic test_backpressure;
        int oe_n = 0, rx0;
        bit stable = 1'b1, to;
        word_ready = 1'b0;
        send_req(9'd5, 4'd15);
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (rom_oe) oe_n++;
            stray = (c == 25);
            if (c >= 8 && (word_valid !== 1'b1 || word_data !== rom_word(9'd5) || word_last !== 1'b0)) stable = 1'b0;
        end
        stray = 1'b0;
        n_checks++; if (oe_n != 8) begin n_fail++; $display("FAIL bp_stall_reads: got %0d, expected 8", oe_n); end
        n_checks++; if (!stable) begin n_fail++; $display("FAIL bp_hold: got data=%h valid=%b, expected stable %h", word_data, word_valid, rom_word(9'd5)); end
        rx0 = n_rx;
        word_ready = 1'b1;
        wait_idle(300, to);
        n_checks++; if (to || n_rx - rx0 != 16) begin n_fail++; $display("FAIL bp_drain: got %0d words timeout=%0b, expected 16", n_rx - rx0, to); end
    endtask

    task automatic test_reset_mid;
        int rx0;
        bit quiet = 1'b1, to;
        word_ready = 1'b1;
        send_req(9'd0, 4'd15);
        repeat (3) begin @(posedge clk); #1; end
        reset_n = 1'b0;
        exp_q.delete();
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if ({req_ready, rom_oe, rom_address, word_valid, word_data, word_last, busy} !== {1'b1, 1'b0, 11'h0, 1'b0, 32'h0, 1'b0, 1'b0}) begin
                n_fail++; $display("FAIL midrst_outputs: got rdy=%b oe=%b addr=%h wv=%b data=%h last=%b busy=%b, expected reset values",
                                   req_ready, rom_oe, rom_address, word_valid, word_data, word_last, busy);
            end
            @(posedge clk); #1;
        end
        reset_n = 1'b1;
        rx0 = n_rx;
        @(posedge clk); #1;
        stray = 1'b1;
        @(posedge clk); #1;
        stray = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (word_valid || busy) quiet = 1'b0;
        end
        n_checks++; if (!quiet || n_rx != rx0) begin n_fail++; $display("FAIL midrst_stray: got activity, expected none"); end
        send_req(9'd1, 4'd0);
        wait_idle(30, to);
        n_checks++; if (to || n_rx - rx0 != 1) begin n_fail++; $display("FAIL midrst_after: got %0d words timeout=%0b, expected 1", n_rx - rx0, to); end
    endtask

    task automatic test_back_to_back;
        int oe_n = 0;
        bit got = 1'b0, to;
        word_ready = 1'b1;
        for (int w = 0; w < 2; w++) exp_q.push_back({(w == 1), rom_word(9'(2 + w))});
        exp_q.push_back({1'b1, rom_word(9'd7)});
        req_valid = 1'b1; req_addr = 9'd2; req_len = 4'd1;
        @(posedge clk); #1;
        req_addr = 9'd7; req_len = 4'd0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(posedge clk); #1;
            if (rom_oe) oe_n++;
            if (req_ready) got = 1'b1;
        end
        n_checks++; if (!got || oe_n != 8) begin n_fail++; $display("FAIL b2b_first: got idle=%0b reads=%0d, expected idle after 8", got, oe_n); end
        @(posedge clk); #1;
        n_checks++; if (busy !== 1'b1 || req_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_accept: got busy=%b ready=%b, expected 1 0", busy, req_ready); end
        req_valid = 1'b0;
        wait_idle(40, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL b2b_idle: timeout, expected idle"); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_two();
        test_wrap();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        repeat (4) @(posedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL sb_leftover: got %0d pending, expected 0", exp_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
